// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 prefix folding parser with event FIFO (optional Pause sequence: PS2_PAUSE_SEQ_EN)
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
    input  logic                          evt_ready_i,
    output logic                          evt_valid_o,
    output logic [7:0]                    evt_code_o,
    output logic                          evt_ext_o,
    output logic                          evt_brk_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3
`ifdef PS2_PAUSE_SEQ_EN
        ,
        S_PAUSE   = 3'd4
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmo_cnt;
    logic            byte_ok;
    logic            is_prefix;
    logic            tmo_hit;
    logic            emit;
    logic [7:0]      emit_code;
    logic            emit_ext;
    logic            emit_brk;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            push;
    logic            pop;

    // 0x00/0xFF are keyboard error codes: invisible to the parser and the timeout
    assign byte_ok   = byte_valid_i && (byte_i != 8'h00) && (byte_i != 8'hFF);
    assign is_prefix = (byte_i == 8'hE0) || (byte_i == 8'hF0) || (byte_i == 8'hE1);
    assign tmo_hit   = (state != S_IDLE) && (tmo_cnt == TMO_LAST);

`ifdef PS2_PAUSE_SEQ_EN
    logic [2:0] pause_left;

    // Remaining Pause bytes to swallow after the leading 0xE1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_left <= 3'd0;
        end else if (state == S_IDLE && byte_ok && byte_i == 8'hE1) begin
            pause_left <= 3'd7;
        end else if (state == S_PAUSE && byte_ok) begin
            pause_left <= pause_left - 3'd1;
        end
    end
`endif

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parser next state; an expiring timeout overrides any byte in the same cycle
    always_comb begin
        state_nxt = state;
        if (tmo_hit) begin
            state_nxt = S_IDLE;
        end else if (byte_ok) begin
            case (state)
                S_IDLE: begin
                    if (byte_i == 8'hE0)      state_nxt = S_EXT;
                    else if (byte_i == 8'hF0) state_nxt = S_BRK;
`ifdef PS2_PAUSE_SEQ_EN
                    else if (byte_i == 8'hE1) state_nxt = S_PAUSE;
`endif
                    else                      state_nxt = S_IDLE;
                end
                S_EXT: begin
                    if (byte_i == 8'hF0)      state_nxt = S_EXT_BRK;
                    else if (byte_i == 8'hE0) state_nxt = S_EXT;
                    else                      state_nxt = S_IDLE;
                end
                S_BRK: begin
                    if (byte_i == 8'hF0)      state_nxt = S_BRK;
                    else if (byte_i == 8'hE0) state_nxt = S_EXT;
                    else                      state_nxt = S_IDLE;
                end
`ifdef PS2_PAUSE_SEQ_EN
                S_PAUSE: begin
                    if (pause_left == 3'd1)   state_nxt = S_IDLE;
                end
`endif
                default:                      state_nxt = S_IDLE;
            endcase
        end
    end

    // Parser outputs: which byte completes an event and with which flags
    always_comb begin
        emit      = 1'b0;
        emit_code = byte_i;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        if (!tmo_hit && byte_ok) begin
            case (state)
                S_IDLE:    emit = !is_prefix;
                S_EXT: begin
                    emit     = !is_prefix;
                    emit_ext = 1'b1;
                end
                S_BRK: begin
                    emit     = !is_prefix;
                    emit_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    emit     = !is_prefix;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
`ifdef PS2_PAUSE_SEQ_EN
                S_PAUSE: begin
                    emit      = (pause_left == 3'd1);
                    emit_code = 8'h77;
                    emit_ext  = 1'b1;
                end
`endif
                default:   emit = 1'b0;
            endcase
        end
    end

    // Idle-cycle counter for abandoning half-received prefix sequences
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE || byte_ok || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end

    assign full = (count == CNT_FULL);
    assign pop  = evt_valid_o && evt_ready_i;
    assign push = emit && (!full || pop);

    // Event storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {emit_code, emit_ext, emit_brk};
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            overflow_o <= emit && full && !pop;
        end
    end

    assign evt_valid_o = (count != '0);
    assign level_o     = count;
    assign {evt_code_o, evt_ext_o, evt_brk_o} = evt_valid_o ? mem[rd_ptr] : 10'd0;

endmodule
